// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample factor and baud divider calculation.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned HALF_BIT   = OVERSAMPLE / 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    // Clocks per oversample tick, truncated, never below 1.
    function automatic int unsigned calc_div(input int unsigned freq_mhz,
                                             input int unsigned baudrate);
        longint unsigned num;
        longint unsigned den;
        longint unsigned quo;
        num = 64'(freq_mhz) * 64'd1_000_000;
        den = 64'(baudrate) * 64'(OVERSAMPLE);
        if (den == 64'd0) begin
            return 1;
        end
        quo = num / den;
        if (quo < 64'd1) begin
            return 1;
        end
        return 32'(quo);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle 16x oversample tick.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned FREQ     = 10,
    parameter int unsigned BAUDRATE = 19200
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int unsigned DIV   = calc_div(FREQ, BAUDRATE);
    localparam int unsigned CNT_W = $clog2(DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap_c;

    assign wrap_c = (cnt == CNT_MAX);

    // Tick is registered off the terminal count, so the first one lands DIV cycles after reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt    <= '0;
            o_tick <= 1'b0;
        end else begin
            o_tick <= wrap_c;
            cnt    <= wrap_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: RX synchronizer, oversampling tick and serial-to-parallel FSM.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned NB_DATA  = 8,
    parameter int unsigned FREQ     = 10,
    parameter int unsigned BAUDRATE = 19200,
    parameter int unsigned SB_TICK  = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx,
    output logic               o_tick,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err
);

    localparam int unsigned S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int unsigned S_W   = $clog2(S_MAX);
    localparam int unsigned N_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [S_W-1:0] S_HALF = S_W'(HALF_BIT - 1);
    localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(NB_DATA - 1);

    logic               rx_meta;
    logic               rx_s;

    state_t             state;
    state_t             state_nx;
    logic [S_W-1:0]     s_cnt;
    logic [S_W-1:0]     s_nx;
    logic [N_W-1:0]     n_cnt;
    logic [N_W-1:0]     n_nx;
    logic [NB_DATA-1:0] shift;
    logic [NB_DATA-1:0] shift_nx;
    logic [NB_DATA-1:0] data_nx;
    logic               done_nx;
    logic               ferr_nx;

    uart_baud_tick #(
        .FREQ     (FREQ),
        .BAUDRATE (BAUDRATE)
    ) u_baud_tick (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (o_tick)
    );

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_IDLE;
            s_cnt       <= '0;
            n_cnt       <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nx;
            s_cnt       <= s_nx;
            n_cnt       <= n_nx;
            shift       <= shift_nx;
            o_data      <= data_nx;
            o_rx_done   <= done_nx;
            o_frame_err <= ferr_nx;
        end
    end

    // Samples land on bit centres: half a bit into START, then a full bit per data/stop bit.
    always_comb begin
        state_nx = state;
        s_nx     = s_cnt;
        n_nx     = n_cnt;
        shift_nx = shift;
        data_nx  = o_data;
        done_nx  = 1'b0;
        ferr_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nx = ST_START;
                    s_nx     = '0;
                end
            end
            ST_START: begin
                if (o_tick) begin
                    if (s_cnt == S_HALF) begin
                        if (!rx_s) begin
                            state_nx = ST_DATA;
                            s_nx     = '0;
                            n_nx     = '0;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        s_nx = s_cnt + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (o_tick) begin
                    if (s_cnt == S_BIT) begin
                        s_nx     = '0;
                        shift_nx = {rx_s, shift[NB_DATA-1:1]};
                        if (n_cnt == N_LAST) begin
                            state_nx = ST_STOP;
                        end else begin
                            n_nx = n_cnt + N_W'(1);
                        end
                    end else begin
                        s_nx = s_cnt + S_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (o_tick) begin
                    if (s_cnt == S_STOP) begin
                        state_nx = ST_IDLE;
                        data_nx  = shift;
                        done_nx  = 1'b1;
                        ferr_nx  = ~rx_s;
                    end else begin
                        s_nx = s_cnt + S_W'(1);
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized self-checking bench for uart_rx_core against a frame-level reference model.
module tb_uart_rx_core;

    localparam int unsigned NB_DATA     = 8;
    localparam int unsigned FREQ        = 10;
    localparam int unsigned BAUDRATE    = 192000;
    localparam int unsigned SB_TICK     = 16;
    localparam int unsigned TICK_DIV    = 3;
    localparam int unsigned CLK_PER_BIT = TICK_DIV * 16;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
    } frame_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               rx = 1'b1;
    logic               o_tick;
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done;
    logic               o_frame_err;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    frame_t      exp_q[$];
    frame_t      cur;
    logic [7:0]  model_data = 8'h00;
    logic        prev_done = 1'b0;
    logic        hold_low = 1'b0;
    int unsigned hold_strobes = 0;
    int unsigned strobes = 0;

    uart_rx_core #(
        .NB_DATA  (NB_DATA),
        .FREQ     (FREQ),
        .BAUDRATE (BAUDRATE),
        .SB_TICK  (SB_TICK)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_rx        (rx),
        .o_tick      (o_tick),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            if (n_fails <= 40) begin
                $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
            end
        end
    endtask

    // Frame-level monitor: each strobe must match the next frame the bench put on the line.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_data = 8'h00;
            exp_q.delete();
            prev_done = 1'b0;
            check_eq("rst_done", 32'(o_rx_done), 32'd0);
            check_eq("rst_data", 32'(o_data), 32'd0);
        end else begin
            if (o_rx_done) begin
                strobes++;
                check_eq("done_width", 32'(prev_done), 32'd0);
                if (hold_low) begin
                    hold_strobes++;
                    model_data = 8'h00;
                    check_eq("hold_ferr", 32'(o_frame_err), 32'd1);
                end else if (exp_q.size() == 0) begin
                    check_eq("spurious_strobe", 32'(exp_q.size()), 32'd1);
                end else begin
                    cur = exp_q.pop_front();
                    model_data = cur.data;
                    check_eq("frame_err", 32'(o_frame_err), 32'(cur.ferr));
                end
            end else begin
                check_eq("ferr_idle", 32'(o_frame_err), 32'd0);
            end
            check_eq("data_hold", 32'(o_data), 32'(model_data));
            prev_done = o_rx_done;
        end
    end

    task automatic drive_bit(input logic b, input int unsigned clocks);
        rx = b;
        repeat (clocks) @(posedge clk);
    endtask

    // Bad stop bits stay low well past the sample point, then the line returns high.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        frame_t f;
        drive_bit(1'b0, CLK_PER_BIT);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], CLK_PER_BIT);
        end
        f.data = d;
        f.ferr = ~stop_ok;
        exp_q.push_back(f);
        if (stop_ok) begin
            drive_bit(1'b1, CLK_PER_BIT);
        end else begin
            drive_bit(1'b0, 34);
            drive_bit(1'b1, CLK_PER_BIT - 34);
        end
    endtask

    task automatic drain(input string tag);
        int unsigned budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ticks;
        int unsigned snap;
        logic [7:0]  d;
        logic        ok;
        int unsigned gap;

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tick", 32'(o_tick), 32'd0);
        check_eq("rst_ferr", 32'(o_frame_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tick cadence: one pulse every third clock, first after three edges.
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            check_eq("tick_phase", 32'(o_tick), 32'((i % 3) == 0));
        end
        ticks = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (o_tick) ticks++;
        end
        check_eq("tick_rate", ticks, 32'd100);
        check_eq("idle_no_strobe", strobes, 32'd0);

        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        drain("drain_basic");
        check_eq("basic_strobes", strobes, 32'd2);

        // Short low glitch must be rejected as a false start.
        snap = strobes;
        drive_bit(1'b0, 12);
        drive_bit(1'b1, 200);
        check_eq("glitch_no_strobe", strobes, snap);
        send_frame(8'h96, 1'b1);
        drain("drain_after_glitch");

        send_frame(8'h55, 1'b0);
        drive_bit(1'b1, 60);
        drain("drain_frame_err");

        // Reset in the middle of a frame aborts it.
        drive_bit(1'b0, CLK_PER_BIT);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, CLK_PER_BIT);
        #2;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b1;
        snap  = strobes;
        drive_bit(1'b1, 100);
        check_eq("abort_no_strobe", strobes, snap);
        send_frame(8'h81, 1'b1);
        drain("drain_after_reset");

        for (int k = 0; k < 20; k++) begin
            d   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 4) != 0);
            gap = ok ? $urandom_range(0, 60) : 48 + $urandom_range(0, 40);
            send_frame(d, ok);
            if (gap != 0) drive_bit(1'b1, gap);
        end
        drain("drain_random");

        // Line stuck low: a stream of all-zero frames with framing errors.
        drive_bit(1'b1, 100);
        hold_low = 1'b1;
        drive_bit(1'b0, 1600);
        check_eq("hold_frames", hold_strobes, 32'd3);
        #2;
        rst_n    = 1'b0;
        hold_low = 1'b0;
        rx       = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b1;
        snap  = strobes;
        drive_bit(1'b1, 600);
        check_eq("final_quiet", strobes, snap);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
